frame_ram_arbiter: RTL and testbench

Single-port frame-buffer RAM scheduler for the VGA serial display path. The serial loader writes pixel words through a valid/ready handshake, and the VGA pixel pipeline reads words sequentially during the visible region. The block owns the RAM port and grants it to the reader while `visible` is high and to the writer during blanking. It keeps independent wrapping read and write pointers and resynchronises the read pointer on each frame start.

---
 rtl/frame_ram_arbiter.sv | 89 ++++++++
 tb/tb_frame_ram_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter: shares one frame RAM port between the VGA reader (visible) and the serial writer (blanking).
// Define FRAME_RAM_ARB_STALL_CNT_EN to add stall_cnt, a saturating count of cycles the writer was held off.
module frame_ram_arbiter #(
   parameter  int RAM_WIDTH = 32,
   parameter  int N_BITS    = 480*360*24,
   localparam int RAM_DEPTH = N_BITS/RAM_WIDTH,
   localparam int ADDR_BITS = $clog2(RAM_DEPTH),
   localparam logic [ADDR_BITS-1:0] MAX_ADDR = ADDR_BITS'(RAM_DEPTH-1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 visible,
   input  logic                 frame_start,
   input  logic [RAM_WIDTH-1:0] wr_data,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   output logic                 wr_frame_done,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic                 ram_we,
   output logic [RAM_WIDTH-1:0] ram_wdata,
   input  logic [RAM_WIDTH-1:0] ram_rdata,
`ifdef FRAME_RAM_ARB_STALL_CNT_EN
   output logic [15:0]          stall_cnt,
`endif
   output logic [RAM_WIDTH-1:0] data_out,
   output logic                 rd_valid
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [RAM_WIDTH-1:0] data_q, data_d;
   logic                 issued_q, rd_valid_q, done_q, done_d;
   logic                 rd_st, wr_st, wr_acc;

   assign rd_st = state_q == READ;
   assign wr_st = state_q == WRITE;
   // visible withdraws ready combinationally so a write never lands in a read cycle
   assign wr_ready = wr_st & ~visible;
   assign wr_acc = wr_valid & wr_ready;
   assign ram_addr = rd_st ? rd_ptr_q : wr_st ? wr_ptr_q : '0;
   assign ram_we = wr_acc;
   assign ram_wdata = wr_st ? wr_data : '0;
   assign data_out = data_q;
   assign rd_valid = rd_valid_q;
   assign wr_frame_done = done_q;

   always_comb begin
      state_d  = visible ? READ : (wr_valid & (state_q == IDLE | wr_st)) ? WRITE : IDLE;
      rd_ptr_d = frame_start ? '0 : rd_st ? ((rd_ptr_q == MAX_ADDR) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      wr_ptr_d = wr_acc ? ((wr_ptr_q == MAX_ADDR) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      done_d   = wr_acc & (wr_ptr_q == MAX_ADDR);
      data_d   = issued_q ? ram_rdata : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         issued_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         data_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         issued_q   <= rd_st;
         rd_valid_q <= issued_q;
         data_q     <= data_d;
         done_q     <= done_d;
      end
   end

`ifdef FRAME_RAM_ARB_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   assign stall_d = frame_start ? '0 : (wr_valid & ~wr_ready & ~&stall_q) ? stall_q + 1'b1 : stall_q;
   assign stall_cnt = stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end
`endif
endmodule

// File: tb/tb_frame_ram_arbiter.sv
// tb_frame_ram_arbiter: directed test-plan scenarios plus random traffic against a transaction-level model.
module tb_frame_ram_arbiter;
   localparam int W = 8;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         visible = 1'b0, frame_start = 1'b0, wr_valid = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic         wr_ready, wr_frame_done, ram_we, rd_valid;
   logic [2:0]   ram_addr;
   logic [W-1:0] ram_wdata, ram_rdata, data_out;
`ifdef FRAME_RAM_ARB_STALL_CNT_EN
   logic [15:0]  stall_cnt;
`endif

   frame_ram_arbiter #(.RAM_WIDTH(W), .N_BITS(64)) dut (
      .clk(clk), .rst(rst), .visible(visible), .frame_start(frame_start),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_frame_done(wr_frame_done), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
`ifdef FRAME_RAM_ARB_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .data_out(data_out), .rd_valid(rd_valid)
   );

   always #5 clk = ~clk;

   logic [W-1:0] mem [D];
   initial for (int i = 0; i < D; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   int n_tests = 0, n_fail = 0, done_seen = 0;
   logic [W-1:0] got_q[$];

   // Reference: who owns the port, where each pointer points, and what word is in flight
   bit           m_reading, m_writing, m_acc, s1_v, e_rv, e_done;
   int           m_rd, m_wr, e_stall;
   logic [W-1:0] m_mem [D];
   logic [W-1:0] s1_d, e_do;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_reading = 0; m_writing = 0; m_acc = 0; s1_v = 0; e_rv = 0; e_done = 0;
      m_rd = 0; m_wr = 0; e_stall = 0; e_do = '0; s1_d = '0;
   endtask

   task automatic model_edge(input bit v, input bit fs, input bit wv, input logic [W-1:0] wd);
      bit rdy;
      rdy = m_writing && !v;
      m_acc = rdy && wv;
      e_rv = s1_v;
      e_do = s1_v ? s1_d : '0;
      s1_v = m_reading;
      s1_d = m_mem[m_rd];
      e_done = m_acc && m_wr == D-1;
      if (m_acc) begin
         m_mem[m_wr] = wd;
         m_wr = (m_wr + 1) % D;
      end
      if (fs) m_rd = 0;
      else if (m_reading) m_rd = (m_rd + 1) % D;
      if (fs) e_stall = 0;
      else if (wv && !rdy && e_stall < 65535) e_stall++;
      if (v) begin
         m_reading = 1; m_writing = 0;
      end else if (m_reading) m_reading = 0;
      else if (!m_writing && wv) m_writing = 1;
      else if (m_writing && !wv) m_writing = 0;
   endtask

   task automatic check_now();
      bit rdy;
      rdy = m_writing && !visible;
      chk("wr_ready", wr_ready, rdy);
      chk("ram_we", ram_we, rdy && wr_valid);
      chk("ram_addr", ram_addr, m_reading ? m_rd : m_writing ? m_wr : 0);
      if (rdy && wr_valid) chk("ram_wdata", ram_wdata, wr_data);
      chk("rd_valid", rd_valid, e_rv);
      chk("data_out", data_out, e_do);
      chk("wr_frame_done", wr_frame_done, e_done);
`ifdef FRAME_RAM_ARB_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, e_stall);
`endif
      if (wr_frame_done) done_seen++;
      if (rd_valid) got_q.push_back(data_out);
   endtask

   task automatic step(input bit v, input bit fs, input bit wv, input logic [W-1:0] wd);
      @(negedge clk);
      visible = v; frame_start = fs; wr_valid = wv; wr_data = wd;
      #1;
      check_now();
      @(posedge clk);
      model_edge(v, fs, wv, wd);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, '0);
   endtask

   initial begin
      int i;
      bit vis;
      model_reset();
      for (int k = 0; k < D; k++) m_mem[k] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      idle(2);

      // fill: words 0x10..0x17 offered back-to-back, each held until accepted
      done_seen = 0;
      i = 0;
      for (int k = 0; k < 20 && i < 8; k++) begin
         step(0, 0, 1, 8'h10 + 8'(i));
         if (m_acc) i++;
      end
      chk("fill_words", i, 8);
      idle(3);
      chk("fill_frame_done", done_seen, 1);

      // read frame after a frame_start
      step(0, 1, 0, '0);
      got_q.delete();
      for (int k = 0; k < 8; k++) step(1, 0, 0, '0);
      idle(4);
      chk("read_count", got_q.size(), 8);
      for (int k = 0; k < 8 && k < got_q.size(); k++) chk("read_word", got_q[k], 8'h10 + 8'(k));

      // wrap: 10 reads without resync
      got_q.delete();
      for (int k = 0; k < 10; k++) step(1, 0, 0, '0);
      idle(4);
      chk("wrap_count", got_q.size(), 10);
      for (int k = 0; k < 10 && k < got_q.size(); k++) chk("wrap_word", got_q[k], 8'h10 + 8'(k % 8));

      // collision: visible rises while writer keeps wr_valid high
      step(0, 0, 1, 8'hA0);
      step(0, 0, 1, 8'hA0);
      step(0, 0, 1, 8'hA1);
      for (int k = 0; k < 3; k++) step(1, 0, 1, 8'hA2);
      for (int k = 0; k < 4; k++) step(0, 0, 1, 8'hA2 + 8'(k));
      idle(3);

      // resync: frame_start in the 3rd read cycle
      step(1, 0, 0, '0);
      step(1, 0, 0, '0);
      step(1, 1, 0, '0);
      for (int k = 0; k < 3; k++) step(1, 0, 0, '0);
      idle(3);

      // async reset mid-read with words in flight
      step(0, 0, 1, 8'h55);
      step(1, 0, 1, 8'h55);
      for (int k = 0; k < 3; k++) step(1, 0, 0, '0);
      @(negedge clk);
      #2 rst = 1'b1;
      visible = 0; frame_start = 0; wr_valid = 0;
      #1;
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_wr_ready", wr_ready, 0);
`ifdef FRAME_RAM_ARB_STALL_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      model_reset();
      @(negedge clk) rst = 1'b0;
      idle(2);

      // random traffic
      vis = 0;
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 9) == 0) vis = ~vis;
         step(vis, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, W'($urandom));
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
